crc8_frame_checker: RTL

- Receive-side counterpart to the team's CRC-8 generator: consumes a byte stream framed by a last flag, where the final byte of each frame is the transmitted CRC-8.
- Recomputes the CRC over every byte of the frame, including the trailing CRC byte, and checks for a zero residue.
- Reports one status word per frame through a valid/ready handshake.
- Sits between a byte-level link receiver and the packet consumer.

---
 rtl/crc8_frame_checker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker: recomputes the CRC over each frame (trailing CRC byte
// included), then reports one status word per frame through a valid/ready handshake.
module crc8_frame_checker #(
   parameter logic [7:0]  POLYNOMIAL = 8'h07,
   parameter int unsigned MIN_LEN    = 2,
   parameter int unsigned LEN_W      = 16,
   parameter int unsigned ERR_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [7:0]       data_i,
   input  logic             data_valid_i,
   input  logic             data_last_i,
   output logic             data_ready_o,
   output logic             status_valid_o,
   input  logic             status_ready_i,
   output logic             crc_ok_o,
   output logic             runt_o,
   output logic [LEN_W-1:0] frame_len_o,
   output logic [7:0]       residue_o,
   output logic [ERR_W-1:0] err_count_o
);

   localparam logic [LEN_W-1:0] LEN_MAX   = '1;
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;
   localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BODY   = 2'd1,
      STATUS = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [7:0]       crc, crc_d;
   logic [LEN_W-1:0] len, len_d;

   logic             accept_c;
   logic             capture_c;
   logic [7:0]       crc_step_c;
   logic [LEN_W-1:0] len_inc_c;
   logic             runt_c;
   logic             ok_c;

   // One byte through the MSB-first CRC register, bitwise (no table).
   function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] byte_in);
      logic [7:0] c;
      c = crc_in ^ byte_in;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ POLYNOMIAL) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

   assign accept_c   = data_valid_i && data_ready_o;
   assign crc_step_c = crc8_step(crc, data_i);
   assign len_inc_c  = (len == LEN_MAX) ? len : len + LEN_W'(1);
   assign runt_c     = (len_inc_c < MIN_LEN_L);
   assign ok_c       = (crc_step_c == 8'h00) && !runt_c;

   // Next-state and datapath update.
   always_comb begin
      state_d   = state;
      crc_d     = crc;
      len_d     = len;
      capture_c = 1'b0;
      case (state)
         IDLE, BODY: begin
            if (accept_c) begin
               crc_d = crc_step_c;
               len_d = len_inc_c;
               if (data_last_i) begin
                  state_d   = STATUS;
                  capture_c = 1'b1;
               end else begin
                  state_d = BODY;
               end
            end
         end
         STATUS: begin
            if (status_ready_i) begin
               state_d = IDLE;
               crc_d   = 8'h00;
               len_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            crc_d   = 8'h00;
            len_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         crc   <= 8'h00;
         len   <= '0;
      end else begin
         state <= state_d;
         crc   <= crc_d;
         len   <= len_d;
      end
   end

   // Registered handshake flags follow the next state; status fields latch on STATUS entry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_ready_o   <= 1'b1;
         status_valid_o <= 1'b0;
         crc_ok_o       <= 1'b0;
         runt_o         <= 1'b0;
         frame_len_o    <= '0;
         residue_o      <= 8'h00;
         err_count_o    <= '0;
      end else begin
         data_ready_o   <= (state_d != STATUS);
         status_valid_o <= (state_d == STATUS);
         if (capture_c) begin
            crc_ok_o    <= ok_c;
            runt_o      <= runt_c;
            frame_len_o <= len_inc_c;
            residue_o   <= crc_step_c;
            if (!ok_c && (err_count_o != ERR_MAX)) begin
               err_count_o <= err_count_o + ERR_W'(1);
            end
         end
      end
   end

endmodule
